// File: rtl/buffer_in_out_ram.sv
// Character input FIFO, output code FIFO and dictionary RAM for the LZW datapath.
// Optional macro RAMBUFFER_READ_BYPASS_EN: a same-cycle read of a written address returns the new data.
module buffer_in_out_ram #(
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16,
    parameter int RAM_AW    = 10
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [7:0]  InByte,
    input  logic        InByteValid,
    input  logic        InByteLast,
    output logic        InFull,
    input  logic        InputBuffer,
    output logic [17:0] oBufferIn,
    output logic        EndOfFile,
    input  logic        OutputBuffer,
    input  logic [11:0] iBufferOut,
    input  logic        CloseBuffer,
    output logic [11:0] OutCode,
    output logic        OutValid,
    input  logic        OutReady,
    output logic        OutClosed,
    output logic        OutDone,
    output logic        OutOverflow,
    input  logic        RAMread,
    input  logic        RAMZeroData,
    input  logic        InitRAMCode,
    input  logic        WriteString,
    input  logic [7:0]  ramCode,
    input  logic [15:0] ramString,
    input  logic [17:0] ramDicPointer,
    output logic [15:0] oRAMBuffer
);
    localparam int IAW       = $clog2(IN_DEPTH);
    localparam int OAW       = $clog2(OUT_DEPTH);
    localparam int RAM_WORDS = 1 << RAM_AW;

    logic [8:0]   in_mem [IN_DEPTH];
    logic [IAW-1:0] in_wr;
    logic [IAW-1:0] in_rd;
    logic [IAW:0] in_cnt;
    logic [9:0]   index;
    logic         in_push;
    logic         in_pop;

    assign InFull  = (in_cnt == (IAW + 1)'(IN_DEPTH));
    assign in_push = InByteValid && !InFull;
    assign in_pop  = InputBuffer && (in_cnt != '0) && !EndOfFile;

    always_ff @(posedge Clk) begin
        if (in_push) in_mem[in_wr] <= {InByteLast, InByte};
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            in_wr     <= '0;
            in_rd     <= '0;
            in_cnt    <= '0;
            index     <= '0;
            oBufferIn <= '0;
            EndOfFile <= 1'b0;
        end else begin
            if (in_push) in_wr <= in_wr + 1'b1;
            if (in_pop) begin
                in_rd     <= in_rd + 1'b1;
                oBufferIn <= {index, in_mem[in_rd][7:0]};
                index     <= index + 1'b1;
                if (in_mem[in_rd][8]) EndOfFile <= 1'b1;
            end
            case ({in_push, in_pop})
                2'b10:   in_cnt <= in_cnt + 1'b1;
                2'b01:   in_cnt <= in_cnt - 1'b1;
                default: in_cnt <= in_cnt;
            endcase
        end
    end

    logic [11:0]  out_mem [OUT_DEPTH];
    logic [OAW-1:0] out_wr;
    logic [OAW-1:0] out_rd;
    logic [OAW:0] out_cnt;
    logic         out_full;
    logic         out_req;
    logic         out_push;
    logic         out_pop;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign out_full = (out_cnt == (OAW + 1)'(OUT_DEPTH));
    assign OutValid = (out_cnt != '0);
    assign out_pop  = OutValid && OutReady;
    assign out_req  = OutputBuffer && !OutClosed;
    assign out_push = out_req && (!out_full || out_pop);
    assign OutCode  = OutValid ? out_mem[out_rd] : 12'h000;
    assign OutDone  = OutClosed && !OutValid;

    always_ff @(posedge Clk) begin
        if (out_push) out_mem[out_wr] <= iBufferOut;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            out_wr      <= '0;
            out_rd      <= '0;
            out_cnt     <= '0;
            OutClosed   <= 1'b0;
            OutOverflow <= 1'b0;
        end else begin
            if (out_push) out_wr <= out_wr + 1'b1;
            if (out_pop)  out_rd <= out_rd + 1'b1;
            case ({out_push, out_pop})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
            if (out_req && !out_push) OutOverflow <= 1'b1;
            if (CloseBuffer) OutClosed <= 1'b1;
        end
    end

    logic [15:0]       ram [RAM_WORDS];
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [15:0]       ram_wdata;
    logic              unused_addr_bits;

    assign ram_addr         = ramDicPointer[RAM_AW-1:0];
    assign unused_addr_bits = ^ramDicPointer[17:RAM_AW];

    always_comb begin
        ram_we    = 1'b0;
        ram_wdata = 16'h0000;
        if (RAMZeroData) begin
            ram_we    = 1'b1;
            ram_wdata = 16'h0000;
        end else if (InitRAMCode) begin
            ram_we    = 1'b1;
            ram_wdata = {8'h00, ramCode};
        end else if (WriteString) begin
            ram_we    = 1'b1;
            ram_wdata = ramString;
        end
    end

    always_ff @(posedge Clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            oRAMBuffer <= 16'h0000;
        end else if (RAMread) begin
`ifdef RAMBUFFER_READ_BYPASS_EN
            oRAMBuffer <= ram_we ? ram_wdata : ram[ram_addr];
`else
            oRAMBuffer <= ram[ram_addr];
`endif
        end
    end
endmodule

// File: tb/tb_buffer_in_out_ram.sv
// Randomised and directed bench for buffer_in_out_ram against a queue-based reference model.
module tb_buffer_in_out_ram;
    logic        Clk = 1'b0;
    logic        reset;
    logic [7:0]  InByte;
    logic        InByteValid, InByteLast, InFull, InputBuffer;
    logic [17:0] oBufferIn;
    logic        EndOfFile;
    logic        OutputBuffer;
    logic [11:0] iBufferOut;
    logic        CloseBuffer;
    logic [11:0] OutCode;
    logic        OutValid, OutReady, OutClosed, OutDone, OutOverflow;
    logic        RAMread, RAMZeroData, InitRAMCode, WriteString;
    logic [7:0]  ramCode;
    logic [15:0] ramString;
    logic [17:0] ramDicPointer;
    logic [15:0] oRAMBuffer;

    buffer_in_out_ram dut (
        .Clk(Clk), .reset(reset),
        .InByte(InByte), .InByteValid(InByteValid), .InByteLast(InByteLast), .InFull(InFull),
        .InputBuffer(InputBuffer), .oBufferIn(oBufferIn), .EndOfFile(EndOfFile),
        .OutputBuffer(OutputBuffer), .iBufferOut(iBufferOut), .CloseBuffer(CloseBuffer),
        .OutCode(OutCode), .OutValid(OutValid), .OutReady(OutReady), .OutClosed(OutClosed),
        .OutDone(OutDone), .OutOverflow(OutOverflow),
        .RAMread(RAMread), .RAMZeroData(RAMZeroData), .InitRAMCode(InitRAMCode),
        .WriteString(WriteString), .ramCode(ramCode), .ramString(ramString),
        .ramDicPointer(ramDicPointer), .oRAMBuffer(oRAMBuffer)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [8:0]  in_q[$];
    logic [11:0] exp_q[$];
    logic [17:0] m_buf;
    int          m_index;
    logic        m_eof, m_closed, m_ovf;
    logic [15:0] m_ram [1024];
    bit          m_known [1024];
    logic [15:0] m_rd;
    bit          m_rd_known;

    task automatic model_reset();
        in_q.delete();
        exp_q.delete();
        m_buf = '0; m_index = 0; m_eof = 0; m_closed = 0; m_ovf = 0;
        m_rd = '0; m_rd_known = 1;
    endtask

    task automatic model_update();
        int a;
        bit w;
        logic [15:0] wd;
        logic [8:0] head;
        bit in_full_now, do_pop, out_pop;
        in_full_now = (in_q.size() == 16);
        do_pop = InputBuffer && (in_q.size() > 0) && !m_eof;
        if (do_pop) begin
            head = in_q.pop_front();
            m_buf = {10'(m_index), head[7:0]};
            m_index = (m_index + 1) % 1024;
            if (head[8]) m_eof = 1;
        end
        if (InByteValid && !in_full_now) in_q.push_back({InByteLast, InByte});

        out_pop = OutReady && (exp_q.size() > 0);
        if (OutputBuffer && !m_closed) begin
            if (exp_q.size() < 16 || out_pop) exp_q.push_back(iBufferOut);
            else m_ovf = 1;
        end
        if (out_pop) void'(exp_q.pop_front());
        if (CloseBuffer) m_closed = 1;

        a  = int'(ramDicPointer[9:0]);
        w  = RAMZeroData || InitRAMCode || WriteString;
        wd = RAMZeroData ? 16'h0000 : InitRAMCode ? {8'h00, ramCode} : ramString;
        if (RAMread) begin
`ifdef RAMBUFFER_READ_BYPASS_EN
            if (w) begin m_rd = wd; m_rd_known = 1; end
            else begin m_rd = m_ram[a]; m_rd_known = m_known[a]; end
`else
            m_rd = m_ram[a]; m_rd_known = m_known[a];
`endif
        end
        if (w) begin m_ram[a] = wd; m_known[a] = 1; end
    endtask

    task automatic compare();
        check("oBufferIn", 32'(oBufferIn), 32'(m_buf));
        check("EndOfFile", 32'(EndOfFile), 32'(m_eof));
        check("InFull", 32'(InFull), 32'(in_q.size() == 16));
        check("OutValid", 32'(OutValid), 32'(exp_q.size() > 0));
        check("OutCode", 32'(OutCode), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
        check("OutClosed", 32'(OutClosed), 32'(m_closed));
        check("OutDone", 32'(OutDone), 32'(m_closed && exp_q.size() == 0));
        check("OutOverflow", 32'(OutOverflow), 32'(m_ovf));
        if (m_rd_known) check("oRAMBuffer", 32'(oRAMBuffer), 32'(m_rd));
    endtask

    task automatic idle();
        InByte = 0; InByteValid = 0; InByteLast = 0; InputBuffer = 0;
        OutputBuffer = 0; iBufferOut = 0; CloseBuffer = 0; OutReady = 0;
        RAMread = 0; RAMZeroData = 0; InitRAMCode = 0; WriteString = 0;
        ramCode = 0; ramString = 0; ramDicPointer = 0;
    endtask

    task automatic step();
        model_update();
        @(posedge Clk);
        #1;
        compare();
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        reset = 1'b0;
        model_reset();
        compare();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_mid();
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare();
        #1 reset = 1'b0;
        idle();
    endtask

    task automatic push_byte(input logic [7:0] b, input logic last);
        InByte = b; InByteValid = 1; InByteLast = last;
        step();
    endtask

    task automatic ram_op(input int op, input logic [9:0] a, input logic [15:0] val, input logic rd);
        ramDicPointer = {8'h00, a};
        RAMread = rd;
        RAMZeroData = (op == 1);
        InitRAMCode = (op == 2);
        WriteString = (op == 3);
        ramCode = val[7:0];
        ramString = val;
        step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) m_known[i] = 0;
        idle();
        do_reset();

        // Request with empty input FIFO: nothing changes
        InputBuffer = 1; step();
        check("empty_req_buf", 32'(oBufferIn), 32'h0);
        check("empty_req_eof", 32'(EndOfFile), 32'h0);

        push_byte(8'h41, 0);
        push_byte(8'h42, 1);
        InputBuffer = 1; step();
        check("first_char", 32'(oBufferIn), 32'h00041);
        check("eof_after_first", 32'(EndOfFile), 32'h0);
        InputBuffer = 1; step();
        check("second_char", 32'(oBufferIn), 32'h00142);
        check("eof_after_last", 32'(EndOfFile), 32'h1);
        push_byte(8'h55, 0);
        InputBuffer = 1; step();
        check("req_after_eof", 32'(oBufferIn), 32'h00142);

        // Output FIFO overflow and ordering
        for (int i = 0; i < 17; i++) begin
            OutputBuffer = 1; iBufferOut = 12'(12'h100 + i); step();
        end
        check("ovf_set", 32'(OutOverflow), 32'h1);
        check("first_code", 32'(OutCode), 32'h100);
        for (int i = 0; i < 16; i++) begin
            check("pop_order", 32'(OutCode), 32'(12'h100 + i));
            OutReady = 1; step();
        end
        check("drained", 32'(OutValid), 32'h0);

        // Push together with close
        OutputBuffer = 1; iBufferOut = 12'hABC; CloseBuffer = 1; step();
        check("close_code", 32'(OutCode), 32'hABC);
        check("closed", 32'(OutClosed), 32'h1);
        check("not_done", 32'(OutDone), 32'h0);
        OutReady = 1; step();
        check("done", 32'(OutDone), 32'h1);
        OutputBuffer = 1; iBufferOut = 12'h123; step();
        check("push_after_close", 32'(OutValid), 32'h0);

        // Dictionary RAM
        ram_op(2, 10'd5, 16'h007F, 0);
        ram_op(0, 10'd5, 16'h0000, 1);
        check("init_code", 32'(oRAMBuffer), 32'h007F);
        RAMZeroData = 1; ramDicPointer = 18'd5; WriteString = 1; ramString = 16'h4142; step();
        ram_op(0, 10'd5, 16'h0000, 1);
        check("zero_priority", 32'(oRAMBuffer), 32'h0000);
        ram_op(3, 10'd7, 16'h1234, 0);
        ram_op(3, 10'd7, 16'h5678, 1);
`ifdef RAMBUFFER_READ_BYPASS_EN
        check("rw_same_cycle", 32'(oRAMBuffer), 32'h5678);
`else
        check("rw_same_cycle", 32'(oRAMBuffer), 32'h1234);
`endif
        ram_op(0, 10'd7, 16'h0000, 0);
        check("read_hold", 32'(oRAMBuffer), 32'(m_rd));
        ram_op(0, 10'd7, 16'h0000, 1);
        check("after_write", 32'(oRAMBuffer), 32'h5678);

        // RAM contents survive an asynchronous reset
        reset_mid();
        check("reset_ram_out", 32'(oRAMBuffer), 32'h0);
        ram_op(0, 10'd7, 16'h0000, 1);
        check("ram_kept", 32'(oRAMBuffer), 32'h5678);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            InByteValid   = 1'($urandom_range(0, 1));
            InByte        = 8'($urandom);
            InByteLast    = ($urandom_range(0, 40) == 0);
            InputBuffer   = 1'($urandom_range(0, 1));
            OutputBuffer  = ($urandom_range(0, 2) != 0);
            iBufferOut    = 12'($urandom);
            CloseBuffer   = ($urandom_range(0, 300) == 0);
            OutReady      = ($urandom_range(0, 2) == 0);
            RAMread       = 1'($urandom_range(0, 1));
            RAMZeroData   = ($urandom_range(0, 5) == 0);
            InitRAMCode   = ($urandom_range(0, 3) == 0);
            WriteString   = ($urandom_range(0, 2) == 0);
            ramCode       = 8'($urandom);
            ramString     = 16'($urandom);
            ramDicPointer = {8'($urandom), 10'($urandom_range(0, 15))};
            step();
            if ($urandom_range(0, 150) == 0) reset_mid();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
